// File: rtl/nubus_slave_if.sv
// NuBus slave-side bus and local memory request signals.
// The slave modport is the responder's view; master is the bus/memory side.
interface nubus_slave_if;
    logic [3:0]  nub_idn;
    logic        nub_startn;
    logic        nub_ackn;
    logic        nub_tm1n;
    logic        nub_tm0n;
    logic [31:0] nub_adn;

    logic        slv_ackcy;
    logic        slv_tm1n_o;
    logic        slv_tm0n_o;
    logic [31:0] slv_adn_o;
    logic        slv_adoe_o;
    logic        slv_busy_o;

    logic        mem_valid;
    logic        mem_write;
    logic [29:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_error;

    modport slave (
        input  nub_idn, nub_startn, nub_ackn, nub_tm1n, nub_tm0n, nub_adn,
        output slv_ackcy, slv_tm1n_o, slv_tm0n_o, slv_adn_o, slv_adoe_o, slv_busy_o,
        output mem_valid, mem_write, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ready, mem_rdata, mem_error
    );

    modport master (
        output nub_idn, nub_startn, nub_ackn, nub_tm1n, nub_tm0n, nub_adn,
        input  slv_ackcy, slv_tm1n_o, slv_tm0n_o, slv_adn_o, slv_adoe_o, slv_busy_o,
        input  mem_valid, mem_write, mem_addr, mem_wstrb, mem_wdata,
        output mem_ready, mem_rdata, mem_error
    );
endinterface

// File: rtl/nubus_slave.sv
// NuBus slave transaction responder: decodes slot/superslot addresses, runs one
// local memory request per transfer and returns a single-cycle ACK with status.
//
// state  | meaning
// IDLE   | waiting for START with an address that matches our ID
// DATA   | one cycle; write data is on AD, sampled at its end
// MEM    | local request outstanding; wait timer running
// ACK    | one cycle; ACK status (and read data) driven on the bus
module nubus_slave #(
    parameter bit          SUPER_EN = 1'b1,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic         nub_clkn,
    input  logic         nub_resetn,
    nubus_slave_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_MEM  = 2'd2,
        S_ACK  = 2'd3
    } state_t;

    localparam logic [7:0] WAIT_LOAD = 8'(WAIT_MAX - 1);

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] w_ad;
    logic [3:0]  w_id;
    logic        w_tm1;
    logic        w_tm0;
    logic        w_req;
    logic        w_match;
    logic [3:0]  w_strb;
    logic        w_unsup;

    logic [7:0]  r_wait;
    logic        r_unsup;
    logic        r_write;
    logic [29:0] r_addr;
    logic [3:0]  r_strb;
    logic [31:0] r_wdata;
    logic        r_mem_valid;
    logic        r_busy;
    logic        r_ackcy;
    logic        r_tm1n;
    logic        r_tm0n;
    logic        r_adoe;
    logic [31:0] r_adn;

    assign w_ad    = ~bus.nub_adn;
    assign w_id    = ~bus.nub_idn;
    assign w_tm1   = ~bus.nub_tm1n;
    assign w_tm0   = ~bus.nub_tm0n;
    // START together with ACK is an attention cycle, never a transfer
    assign w_req   = ~bus.nub_startn & bus.nub_ackn;
    assign w_match = (w_ad[31:24] == {4'hF, w_id}) ||
                     (SUPER_EN && (w_ad[31:28] == w_id) && (w_ad[31:28] != 4'hF));

    always_comb begin
        w_strb  = 4'b0000;
        w_unsup = 1'b0;
        if (!w_tm0) begin
            w_strb = 4'b0001 << w_ad[1:0];
        end else begin
            case (w_ad[1:0])
                2'b00:   w_strb = 4'b1111;
                2'b10:   w_strb = 4'b0011;
                2'b11:   w_strb = 4'b1100;
                default: w_unsup = 1'b1;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_req && w_match) w_state_nxt = S_DATA;
            S_DATA: w_state_nxt = r_unsup ? S_ACK : S_MEM;
            S_MEM:  if (bus.mem_ready || (r_wait == 8'd0)) w_state_nxt = S_ACK;
            S_ACK:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge nub_clkn) begin
        if (!nub_resetn) r_state <= S_IDLE;
        else             r_state <= w_state_nxt;
    end

    // Every bus/memory output is a flop, set up one edge ahead from next-state
    always_ff @(posedge nub_clkn) begin
        if (!nub_resetn) begin
            r_wait      <= 8'd0;
            r_unsup     <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= 30'd0;
            r_strb      <= 4'd0;
            r_wdata     <= 32'd0;
            r_mem_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_ackcy     <= 1'b0;
            r_tm1n      <= 1'b1;
            r_tm0n      <= 1'b1;
            r_adoe      <= 1'b0;
            r_adn       <= 32'hFFFF_FFFF;
        end else begin
            r_mem_valid <= (w_state_nxt == S_MEM);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_ackcy     <= (w_state_nxt == S_ACK);
            r_tm1n      <= 1'b1;
            r_tm0n      <= 1'b1;
            r_adoe      <= 1'b0;
            r_adn       <= 32'hFFFF_FFFF;
            case (r_state)
                S_IDLE: begin
                    if (w_req && w_match) begin
                        r_addr  <= w_ad[31:2];
                        r_strb  <= w_strb;
                        r_write <= ~w_tm1;
                        r_unsup <= w_unsup;
                    end
                end
                S_DATA: begin
                    if (r_write) r_wdata <= w_ad;
                    r_wait <= WAIT_LOAD;
                    if (r_unsup) r_tm0n <= 1'b0;
                end
                S_MEM: begin
                    if (bus.mem_ready) begin
                        if (bus.mem_error) begin
                            r_tm0n <= 1'b0;
                        end else if (!r_write) begin
                            r_adoe <= 1'b1;
                            r_adn  <= ~bus.mem_rdata;
                        end
                    end else if (r_wait == 8'd0) begin
                        // try-again-later: both status lines asserted
                        r_tm1n <= 1'b0;
                        r_tm0n <= 1'b0;
                    end else begin
                        r_wait <= r_wait - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.slv_ackcy  = r_ackcy;
    assign bus.slv_tm1n_o = r_tm1n;
    assign bus.slv_tm0n_o = r_tm0n;
    assign bus.slv_adn_o  = r_adn;
    assign bus.slv_adoe_o = r_adoe;
    assign bus.slv_busy_o = r_busy;
    assign bus.mem_valid  = r_mem_valid;
    assign bus.mem_write  = r_write;
    assign bus.mem_addr   = r_addr;
    assign bus.mem_wstrb  = r_strb;
    assign bus.mem_wdata  = r_wdata;

endmodule

// File: tb/tb_nubus_slave.sv
// Scoreboard bench for nubus_slave: directed transfers push expected memory
// requests and ACKs; a negedge monitor pops and compares as the DUT presents them.
module tb_nubus_slave;

    logic clk;
    logic resetn;
    int   cyc;
    int   n_checks;
    int   n_fail;
    int   busy1_cnt;
    int   busy2_cnt;
    bit   mon_en;
    logic prev_valid;

    nubus_slave_if bus ();
    nubus_slave_if bus2 ();

    nubus_slave #(.SUPER_EN(1'b1), .WAIT_MAX(15)) dut (
        .nub_clkn   (clk),
        .nub_resetn (resetn),
        .bus        (bus.slave)
    );

    // Same bus, but superslot decoding disabled
    nubus_slave #(.SUPER_EN(1'b0), .WAIT_MAX(15)) dut_nosuper (
        .nub_clkn   (clk),
        .nub_resetn (resetn),
        .bus        (bus2.slave)
    );

    assign bus2.nub_idn    = bus.nub_idn;
    assign bus2.nub_startn = bus.nub_startn;
    assign bus2.nub_ackn   = bus.nub_ackn;
    assign bus2.nub_tm1n   = bus.nub_tm1n;
    assign bus2.nub_tm0n   = bus.nub_tm0n;
    assign bus2.nub_adn    = bus.nub_adn;
    assign bus2.mem_ready  = bus.mem_ready;
    assign bus2.mem_rdata  = bus.mem_rdata;
    assign bus2.mem_error  = bus.mem_error;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [29:0] addr;
        logic [3:0]  strb;
        logic        write;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct {
        int          cycle;
        logic [1:0]  tmn;
        logic        adoe;
        logic [31:0] adn;
    } ack_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        tm1;
        logic        tm0;
        logic        ackn;
        logic [31:0] wdata;
        int          waits;   // cycle of mem_ready after MEM entry, -1 = never
        logic [31:0] rdata;
        logic        err;
        logic        exp_mem;
        logic [29:0] e_addr;
        logic [3:0]  e_strb;
        logic        exp_ack;
        int          lat;
        logic [1:0]  e_tmn;
        logic        e_adoe;
        logic [31:0] e_adn;
        int          ncyc;
    } vec_t;

    mem_exp_t mem_q[$];
    ack_exp_t ack_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.slv_busy_o === 1'b1)  busy1_cnt++;
            if (bus2.slv_busy_o === 1'b1) busy2_cnt++;
            if (bus.mem_valid && !prev_valid) begin
                if (mem_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_mem_valid: got request addr %h expected none", bus.mem_addr);
                end else begin
                    mem_exp_t m;
                    m = mem_q.pop_front();
                    chk("mem_addr",  {2'b00, bus.mem_addr}, {2'b00, m.addr});
                    chk("mem_wstrb", {28'd0, bus.mem_wstrb}, {28'd0, m.strb});
                    chk("mem_write", {31'd0, bus.mem_write}, {31'd0, m.write});
                    if (m.write) chk("mem_wdata", bus.mem_wdata, m.wdata);
                end
            end
            prev_valid = bus.mem_valid;
            if (bus.slv_ackcy) begin
                if (ack_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_ack: got ACK in cycle %0d expected none", cyc);
                end else begin
                    ack_exp_t a;
                    a = ack_q.pop_front();
                    chk("ack_cycle", cyc, a.cycle);
                    chk("ack_status", {30'd0, bus.slv_tm1n_o, bus.slv_tm0n_o}, {30'd0, a.tmn});
                    chk("ack_adoe", {31'd0, bus.slv_adoe_o}, {31'd0, a.adoe});
                    chk("ack_adn", bus.slv_adn_o, a.adn);
                    chk("ack_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
                end
            end else begin
                chk("idle_outputs", {29'd0, bus.slv_tm1n_o, bus.slv_tm0n_o, bus.slv_adoe_o}, 32'h6);
            end
        end
    end

    task automatic idle_bus();
        bus.nub_startn = 1'b1;
        bus.nub_ackn   = 1'b1;
        bus.nub_tm1n   = 1'b1;
        bus.nub_tm0n   = 1'b1;
        bus.nub_adn    = 32'hFFFF_FFFF;
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = 32'd0;
        bus.mem_error  = 1'b0;
    endtask

    task automatic step(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called just after a rising edge; that cycle becomes cycle n (START)
    task automatic txn(input vec_t v);
        int n;
        n = cyc;
        if (v.exp_mem) mem_q.push_back('{v.e_addr, v.e_strb, ~v.tm1, v.wdata});
        if (v.exp_ack) ack_q.push_back('{n + v.lat, v.e_tmn, v.e_adoe, v.e_adn});
        bus.nub_startn = 1'b0;
        bus.nub_ackn   = v.ackn;
        bus.nub_adn    = ~v.addr;
        bus.nub_tm1n   = ~v.tm1;
        bus.nub_tm0n   = ~v.tm0;
        step(1);
        bus.nub_startn = 1'b1;
        bus.nub_ackn   = 1'b1;
        bus.nub_tm1n   = 1'b1;
        bus.nub_tm0n   = 1'b1;
        bus.nub_adn    = v.tm1 ? 32'hFFFF_FFFF : ~v.wdata;
        step(1);
        bus.nub_adn = 32'hFFFF_FFFF;
        while (cyc < n + v.ncyc) begin
            if (v.waits >= 0 && (cyc - (n + 2)) == v.waits) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = v.rdata;
                bus.mem_error = v.err;
            end else begin
                bus.mem_ready = 1'b0;
                bus.mem_rdata = 32'd0;
                bus.mem_error = 1'b0;
            end
            step(1);
        end
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'd0;
        bus.mem_error = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ackcy"},  {31'd0, bus.slv_ackcy}, 32'd0);
        chk({tag, "_adoe"},   {31'd0, bus.slv_adoe_o}, 32'd0);
        chk({tag, "_adn"},    bus.slv_adn_o, 32'hFFFF_FFFF);
        chk({tag, "_tmn"},    {30'd0, bus.slv_tm1n_o, bus.slv_tm0n_o}, 32'd3);
        chk({tag, "_valid"},  {31'd0, bus.mem_valid}, 32'd0);
        chk({tag, "_write"},  {31'd0, bus.mem_write}, 32'd0);
        chk({tag, "_addr"},   {2'b00, bus.mem_addr}, 32'd0);
        chk({tag, "_wstrb"},  {28'd0, bus.mem_wstrb}, 32'd0);
        chk({tag, "_wdata"},  bus.mem_wdata, 32'd0);
        chk({tag, "_busy"},   {31'd0, bus.slv_busy_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b1;
        int b2;
        cyc = 0; n_checks = 0; n_fail = 0; busy1_cnt = 0; busy2_cnt = 0;
        mon_en = 1'b0; prev_valid = 1'b0;
        bus.nub_idn = ~4'h3;
        idle_bus();
        resetn = 1'b0;
        step(3);
        @(negedge clk);
        chk_reset_values("rst");
        mon_en = 1'b1;
        @(posedge clk); #1;
        resetn = 1'b1;
        step(2);

        // word write, ready in first MEM cycle
        txn('{32'hF300_0010, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 0, 32'd0, 1'b0,
              1'b1, 30'h3CC0_0004, 4'hF, 1'b1, 3, 2'b11, 1'b0, 32'hFFFF_FFFF, 4});
        step(2);
        // byte read, three waits
        txn('{32'hF300_0002, 1'b1, 1'b0, 1'b1, 32'd0, 3, 32'h1122_3344, 1'b0,
              1'b1, 30'h3CC0_0000, 4'h4, 1'b1, 6, 2'b11, 1'b1, 32'hEEDD_CCBB, 7});
        step(2);

        // wrong slot, then attention cycle: neither may start a transfer
        b1 = busy1_cnt;
        txn('{32'hF400_0000, 1'b1, 1'b1, 1'b1, 32'd0, -1, 32'd0, 1'b0,
              1'b0, 30'd0, 4'h0, 1'b0, 0, 2'b11, 1'b0, 32'hFFFF_FFFF, 4});
        txn('{32'hF300_0000, 1'b1, 1'b1, 1'b0, 32'd0, -1, 32'd0, 1'b0,
              1'b0, 30'd0, 4'h0, 1'b0, 0, 2'b11, 1'b0, 32'hFFFF_FFFF, 4});
        chk("filter_busy", busy1_cnt, b1);
        step(2);

        // superslot: accepted with SUPER_EN=1, ignored with SUPER_EN=0
        b2 = busy2_cnt;
        txn('{32'h3000_0000, 1'b0, 1'b1, 1'b1, 32'h1234_5678, 1, 32'd0, 1'b0,
              1'b1, 30'h0C00_0000, 4'hF, 1'b1, 4, 2'b11, 1'b0, 32'hFFFF_FFFF, 5});
        chk("nosuper_busy", busy2_cnt, b2);
        step(2);

        // halfword read with memory error
        txn('{32'hF300_0022, 1'b1, 1'b1, 1'b1, 32'd0, 0, 32'h5555_AAAA, 1'b1,
              1'b1, 30'h3CC0_0008, 4'h3, 1'b1, 3, 2'b10, 1'b0, 32'hFFFF_FFFF, 4});
        step(2);
        // timeout: ready never comes
        txn('{32'hF300_0100, 1'b1, 1'b1, 1'b1, 32'd0, -1, 32'd0, 1'b0,
              1'b1, 30'h3CC0_0040, 4'hF, 1'b1, 17, 2'b00, 1'b0, 32'hFFFF_FFFF, 18});
        step(2);
        // block mode: error ACK straight from DATA, no memory request
        txn('{32'hF300_0005, 1'b1, 1'b1, 1'b1, 32'd0, -1, 32'd0, 1'b0,
              1'b0, 30'd0, 4'h0, 1'b1, 2, 2'b10, 1'b0, 32'hFFFF_FFFF, 3});
        step(2);
        // upper halfword write, two waits
        txn('{32'hF300_0007, 1'b0, 1'b1, 1'b1, 32'hCAFE_F00D, 2, 32'd0, 1'b0,
              1'b1, 30'h3CC0_0001, 4'hC, 1'b1, 5, 2'b11, 1'b0, 32'hFFFF_FFFF, 6});
        step(2);
        // byte write on lane 3
        txn('{32'hF300_00FF, 1'b0, 1'b0, 1'b1, 32'hA5A5_A5A5, 0, 32'd0, 1'b0,
              1'b1, 30'h3CC0_003F, 4'h8, 1'b1, 3, 2'b11, 1'b0, 32'hFFFF_FFFF, 4});
        step(2);

        // reset during MEM: write stalls, resetn low in n+3
        txn('{32'hF300_0080, 1'b0, 1'b1, 1'b1, 32'h7777_0001, -1, 32'd0, 1'b0,
              1'b1, 30'h3CC0_0020, 4'hF, 1'b0, 0, 2'b11, 1'b0, 32'hFFFF_FFFF, 3});
        resetn = 1'b0;
        step(1);
        resetn = 1'b1;
        @(negedge clk);
        chk_reset_values("midrst");
        @(posedge clk); #1;
        step(4);

        // back-to-back: second START in the cycle right after the first ACK
        txn('{32'hF300_0040, 1'b1, 1'b1, 1'b1, 32'd0, 0, 32'h0BAD_F00D, 1'b0,
              1'b1, 30'h3CC0_0010, 4'hF, 1'b1, 3, 2'b11, 1'b1, 32'hF452_0FF2, 4});
        txn('{32'hF300_0044, 1'b0, 1'b1, 1'b1, 32'h0102_0304, 0, 32'd0, 1'b0,
              1'b1, 30'h3CC0_0011, 4'hF, 1'b1, 3, 2'b11, 1'b0, 32'hFFFF_FFFF, 4});
        step(4);

        chk("mem_q_left", mem_q.size(), 32'd0);
        chk("ack_q_left", ack_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
